pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised successor to the basic program counter for the 16-bit CPU datapath.
- Holds the fetch address and supports increment, absolute jump, signed relative branch, and subroutine call/return through an internal return-address stack.
- Sits between the control unit, which drives `op`, and instruction memory, which is addressed by `pc`.
- Stack overflow and underflow are reported as sticky error flags to the control unit.

Parameters:
- AW, 12: address width in bits.
- OW, 8: branch offset width in bits, two's complement; must satisfy OW <= AW.
- DEPTH, 4: return-stack entries; must be >= 1.
- RESET_VECTOR, 0: value `pc` takes on reset and on CLEAR.
- TRAP_VECTOR, 'hFF0: value `pc` takes on a stack fault; used only when PC_TRAP_EN is defined.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when low, all state holds.
- op  input  3  operation select (encoding under Behaviour).
- target  input  AW  absolute address for JUMP and CALL.
- offset  input  OW  signed displacement for BRANCH.
- clr_err  input  1  synchronous clear of the sticky error flags.
- pc  output  AW  registered current fetch address.
- sp  output  $clog2(DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp == DEPTH (combinational from sp).
- stack_empty  output  1  sp == 0 (combinational from sp).
- ovf_err  output  1  sticky: a CALL was issued while the stack was full.
- unf_err  output  1  sticky: a RET was issued while the stack was empty.

Behaviour:
- Reset (asynchronous, rst=1):
  - pc = RESET_VECTOR, sp = 0, ovf_err = 0, unf_err = 0.
  - Stack contents are don't-care.
  - Asserting rst in the middle of any operation aborts it immediately.
- All other updates happen on the rising edge of clk, only when en=1.
- Latency: an op sampled at edge N is visible on `pc`/`sp` after edge N. There is no combinational path from inputs to `pc`.
- op encoding:
  - 000 HOLD: no change.
  - 001 INC: pc <= pc+1, modulo 2^AW (all-ones wraps to 0).
  - 010 JUMP: pc <= target.
  - 011 BRANCH: pc <= pc + sign_extend(offset), modulo 2^AW; wraps in both directions.
  - 100 CALL: stack[sp] <= pc+1 (mod 2^AW); sp <= sp+1; pc <= target.
  - 101 RET: sp <= sp-1; pc <= stack[sp-1].
  - 110 CLEAR: pc <= RESET_VECTOR; sp <= 0. Error flags are unaffected.
  - 111 reserved: behaves as HOLD.
- CALL when stack_full:
  - No push; sp and pc hold.
  - ovf_err <= 1.
- RET when stack_empty:
  - No pop; sp and pc hold.
  - unf_err <= 1.
- Stack is LIFO with no wrap-around. Entries at index >= sp are never read.
- clr_err:
  - Clears both error flags on the next edge, regardless of en.
  - If a new fault occurs in the same cycle as clr_err, the set wins.
- en=0 with a fault-causing op: no fault is flagged.

Optional Feature:
- Macro: PC_TRAP_EN
- Defined:
  - A CALL-on-full or RET-on-empty loads pc <= TRAP_VECTOR in the same edge that sets the error flag.
  - sp is unchanged.
- Undefined:
  - pc holds on a fault, as described under Behaviour.
  - TRAP_VECTOR is ignored.

Test Plan (AW=12, OW=8, DEPTH=4, RESET_VECTOR=0):
- Reset and increment: pulse rst asynchronously between clock edges, then INC for 3 cycles -> pc=0 during reset, then 1, 2, 3; sp=0; both error flags 0.
- Jump and wrap: JUMP target='hFFE, then INC x3 -> pc = 'hFFE, 'hFFF, 'h000, 'h001.
- Signed branch: pc='h010, BRANCH offset=8'hF0 (-16) -> pc='h000. Then BRANCH 8'h7F -> pc='h07F. Then BRANCH 8'h80 (-128) from 'h07F -> pc='hFFF.
- Nested call/return: from pc='h100, CALL 'h200, 'h300, 'h400, 'h500 -> sp=4, stack_full=1. RET x4 -> pc = 'h401, 'h301, 'h201, 'h101; sp=0; stack_empty=1.
- Faults:
  - 5th CALL with stack full -> pc and sp unchanged, ovf_err=1 (pc='hFF0 with PC_TRAP_EN defined).
  - RET with stack empty -> unf_err=1.
  - clr_err together with a new fault -> the flag stays 1.
  - clr_err alone -> both flags 0 after one edge.
- Enable and reset mid-operation: en=0 with op=INC, JUMP, and CALL -> pc and sp frozen for all three. Assert rst after 2 CALLs -> pc=0, sp=0 immediately.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with an internal return-address stack.
// Holds the fetch address. Supports increment, absolute jump, signed
// relative branch, CLEAR, and subroutine call/return. Stack overflow and
// underflow set sticky error flags.
// Optional feature macro: PC_TRAP_EN. When it is defined, a stack fault
// also loads pc with TRAP_VECTOR.
module pc_stack_unit #(
  parameter int AW           = 12,
  parameter int OW           = 8,
  parameter int DEPTH        = 4,
  parameter int RESET_VECTOR = 0,
  parameter int TRAP_VECTOR  = 'hFF0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic [AW-1:0]                target,
  input  logic [OW-1:0]                offset,
  input  logic                         clr_err,
  output logic [AW-1:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  RESET_PC = AW'(RESET_VECTOR);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;
  localparam logic [2:0] OP_CLEAR  = 3'b110;

  if (OW > AW || DEPTH < 1) begin : g_bad_params
    $error("pc_stack_unit: requires OW <= AW and DEPTH >= 1");
  end

`ifdef PC_TRAP_EN
  localparam logic [AW-1:0] TRAP_PC = AW'(TRAP_VECTOR);
`else
  // The trap vector has no effect in this build.
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  logic [AW-1:0]  stack [DEPTH];
  logic [AW-1:0]  pc_nxt;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  off_ext;
  logic [SPW-1:0] sp_nxt;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;
  logic           push;
  logic           ovf_set;
  logic           unf_set;

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign pc_inc      = pc + AW'(1);
  // The index is only used when it is in range: a push needs sp < DEPTH,
  // and a pop needs sp > 0.
  assign push_idx    = IW'(sp);
  assign pop_idx     = IW'(sp - SPW'(1));

  // Sign-extend the branch displacement to the address width.
  always_comb begin
    off_ext = {AW{offset[OW-1]}};
    off_ext[OW-1:0] = offset;
  end

  // Decode the operation into the next pc/sp, stack push and fault events.
  // When en is low, nothing changes and no fault is reported.
  always_comb begin
    pc_nxt  = pc;
    sp_nxt  = sp;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (op)
        OP_HOLD:   pc_nxt = pc;
        OP_INC:    pc_nxt = pc_inc;
        OP_JUMP:   pc_nxt = target;
        OP_BRANCH: pc_nxt = pc + off_ext;
        OP_CALL: begin
          if (stack_full) begin
            ovf_set = 1'b1;
`ifdef PC_TRAP_EN
            pc_nxt  = TRAP_PC;
`endif
          end else begin
            push   = 1'b1;
            sp_nxt = sp + SPW'(1);
            pc_nxt = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            unf_set = 1'b1;
`ifdef PC_TRAP_EN
            pc_nxt  = TRAP_PC;
`endif
          end else begin
            sp_nxt = sp - SPW'(1);
            pc_nxt = stack[pop_idx];
          end
        end
        OP_CLEAR: begin
          pc_nxt = RESET_PC;
          sp_nxt = '0;
        end
        default:   pc_nxt = pc;
      endcase
    end
  end

  // Update pc, sp and the sticky error flags. A new fault wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      sp      <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      sp      <= sp_nxt;
      ovf_err <= ovf_set | (ovf_err & ~clr_err);
      unf_err <= unf_set | (unf_err & ~clr_err);
    end
  end

  // Return-address storage. Its contents after reset are don't-care, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (AW=12, OW=8, DEPTH=4, RESET_VECTOR=0).
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [11:0] target;
  logic [7:0]  offset;
  logic        clr_err;
  logic [11:0] pc;
  logic [2:0]  sp;
  logic        stack_full, stack_empty, ovf_err, unf_err;

  int n_total = 0;
  int n_pass  = 0;

`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, JUMP = 3'd2, BRANCH = 3'd3,
                         CALL = 3'd4, RET = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;

  pc_stack_unit #(.AW(12), .OW(8), .DEPTH(4), .RESET_VECTOR(0), .TRAP_VECTOR('hFF0)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .offset(offset),
    .clr_err(clr_err), .pc(pc), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [2:0]  op;
    logic [11:0] target;
    logic [7:0]  offset;
    logic        clr;
    logic [11:0] pc;
    logic [2:0]  sp;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  // This gives the pc expected after a fault-holding op, which differs when the trap is enabled.
  function automatic logic [11:0] fpc(input logic [11:0] hold_pc);
    return TRAP ? 12'hFF0 : hold_pc;
  endfunction

  task automatic add(input logic e, input logic [2:0] o, input logic [11:0] t,
                     input logic [7:0] f, input logic c, input logic [11:0] p,
                     input logic [2:0] s, input logic ov, input logic un);
    vec_t v;
    v.en = e; v.op = o; v.target = t; v.offset = f; v.clr = c;
    v.pc = p; v.sp = s; v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic e, input logic [2:0] o, input logic [11:0] t,
                       input logic [7:0] f, input logic c);
    @(negedge clk);
    en = e; op = o; target = t; offset = f; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = HOLD; target = '0; offset = '0; clr_err = 1'b0;

    // This table starts from the reset state.
    add(1, INC,    0,      0,     0, 12'h001, 0, 0, 0);
    add(1, INC,    0,      0,     0, 12'h002, 0, 0, 0);
    add(1, INC,    0,      0,     0, 12'h003, 0, 0, 0);
    add(1, JUMP,   12'hFFE, 0,    0, 12'hFFE, 0, 0, 0);
    add(1, INC,    0,      0,     0, 12'hFFF, 0, 0, 0);
    add(1, INC,    0,      0,     0, 12'h000, 0, 0, 0);
    add(1, INC,    0,      0,     0, 12'h001, 0, 0, 0);
    add(1, JUMP,   12'h010, 0,    0, 12'h010, 0, 0, 0);
    add(1, BRANCH, 0,      8'hF0, 0, 12'h000, 0, 0, 0);
    add(1, BRANCH, 0,      8'h7F, 0, 12'h07F, 0, 0, 0);
    add(1, BRANCH, 0,      8'h80, 0, 12'hFFF, 0, 0, 0);
    add(1, JUMP,   12'h100, 0,    0, 12'h100, 0, 0, 0);
    add(1, CALL,   12'h200, 0,    0, 12'h200, 1, 0, 0);
    add(1, CALL,   12'h300, 0,    0, 12'h300, 2, 0, 0);
    add(1, CALL,   12'h400, 0,    0, 12'h400, 3, 0, 0);
    add(1, CALL,   12'h500, 0,    0, 12'h500, 4, 0, 0);
    add(1, CALL,   12'h600, 0,    0, fpc(12'h500), 4, 1, 0);
    add(1, RET,    0,      0,     0, 12'h401, 3, 1, 0);
    add(1, RET,    0,      0,     0, 12'h301, 2, 1, 0);
    add(1, RET,    0,      0,     0, 12'h201, 1, 1, 0);
    add(1, RET,    0,      0,     0, 12'h101, 0, 1, 0);
    add(1, RET,    0,      0,     0, fpc(12'h101), 0, 1, 1);
    add(1, RET,    0,      0,     1, fpc(12'h101), 0, 0, 1);
    add(1, HOLD,   0,      0,     1, fpc(12'h101), 0, 0, 0);
    add(1, JUMP,   12'h050, 0,    0, 12'h050, 0, 0, 0);
    add(0, INC,    0,      0,     0, 12'h050, 0, 0, 0);
    add(0, JUMP,   12'h123, 0,    0, 12'h050, 0, 0, 0);
    add(0, CALL,   12'h321, 0,    0, 12'h050, 0, 0, 0);
    add(0, RET,    0,      0,     0, 12'h050, 0, 0, 0);
    add(1, RSVD,   12'h777, 8'h11, 0, 12'h050, 0, 0, 0);
    add(1, CALL,   12'h0AA, 0,    0, 12'h0AA, 1, 0, 0);
    add(1, CLEAR,  0,      0,     0, 12'h000, 0, 0, 0);
    add(1, RET,    0,      0,     0, fpc(12'h000), 0, 0, 1);
    add(1, CLEAR,  0,      0,     0, 12'h000, 0, 0, 1);
    add(0, HOLD,   0,      0,     1, 12'h000, 0, 0, 0);
    add(1, CALL,   12'h234, 0,    0, 12'h234, 1, 0, 0);
    add(1, RET,    0,      0,     0, 12'h001, 0, 0, 0);

    // Check the reset state while rst is held.
    #2;
    check("reset pc", pc, 12'h000);
    check("reset sp", sp, 3'd0);
    check("reset ovf", ovf_err, 1'b0);
    check("reset unf", unf_err, 1'b0);
    check("reset empty", stack_empty, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Move pc away from 0, then pulse rst between clock edges.
    drive(1, INC, 0, 0, 0);
    drive(1, INC, 0, 0, 0);
    check("pre-pulse pc", pc, 12'h002);
    @(negedge clk); en = 1'b0; #2 rst = 1'b1; #1;
    check("async pulse pc", pc, 12'h000);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].op, vecs[i].target, vecs[i].offset, vecs[i].clr);
      check($sformatf("v%0d pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d sp", i), sp, vecs[i].sp);
      check($sformatf("v%0d ovf", i), ovf_err, vecs[i].ovf);
      check($sformatf("v%0d unf", i), unf_err, vecs[i].unf);
      check($sformatf("v%0d full", i), stack_full, vecs[i].sp == 3'd4);
      check($sformatf("v%0d empty", i), stack_empty, vecs[i].sp == 3'd0);
    end

    // Set a flag, make two calls, then assert rst mid-cycle. The reset must take effect at once.
    drive(1, RET, 0, 0, 0);
    check("seq unf set", unf_err, 1'b1);
    drive(1, CALL, 12'h200, 0, 0);
    drive(1, CALL, 12'h300, 0, 0);
    check("seq two calls sp", sp, 3'd2);
    check("seq two calls pc", pc, 12'h300);
    @(negedge clk); op = CALL; target = 12'h400; #2 rst = 1'b1; #1;
    check("mid rst pc", pc, 12'h000);
    check("mid rst sp", sp, 3'd0);
    check("mid rst unf", unf_err, 1'b0);
    @(posedge clk); #1;
    check("rst held over edge pc", pc, 12'h000);
    @(negedge clk); rst = 1'b0; op = HOLD;
    drive(1, INC, 0, 0, 0);
    check("post rst inc pc", pc, 12'h001);
    check("post rst sp", sp, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
